// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared widths and state encoding for the UART transmit path
package uart_pkg;

  localparam int UART_DATA_W = 8;
  localparam int UART_BUS_W  = 32;

  typedef enum logic {
    ST_IDLE,
    ST_REQ
  } uart_tx_state_e;

endpackage

// File: rtl/sync_fifo_ptr.sv
// rtl/sync_fifo_ptr.sv - power-of-two FIFO storage with read/write pointers and entry count
module sync_fifo_ptr
  import uart_pkg::*;
#(
  parameter  int DEPTH = 16,
  parameter  int W     = UART_DATA_W,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           push,
  input  logic [W-1:0]   push_data,
  input  logic           pop,
  input  logic           flush,
  output logic [W-1:0]   head_data,
  output logic [PTR_W:0] count
);

  logic [W-1:0]     mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;

  assign head_data = mem[rd_ptr];

  // Storage has no reset; only count decides which entries are valid.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Pointers wrap naturally at DEPTH because the width is exactly log2(DEPTH).
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= wr_ptr;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      if (push && !pop) begin
        count <= count + (PTR_W+1)'(1);
      end else if (pop && !push) begin
        count <= count - (PTR_W+1)'(1);
      end
    end
  end

endmodule

// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - byte FIFO feeding the UART core write strobe with ack handshake
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter  int DEPTH = 16,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   wr_en,
  input  logic [UART_DATA_W-1:0] wr_data,
  input  logic                   flush,
  output logic                   full,
  output logic                   empty,
  output logic [PTR_W:0]         level,
  output logic                   overflow,
  input  logic                   ovf_clr,
  output logic                   busy,
  output logic                   uart_dat_we,
  output logic [UART_BUS_W-1:0]  uart_dat_di,
  input  logic                   uart_dat_ack
);

  uart_tx_state_e         state;
  uart_tx_state_e         state_next;
  logic                   pop;
  logic                   push;
  logic [UART_DATA_W-1:0] head_data;
  logic [UART_DATA_W-1:0] out_byte;
  logic [PTR_W:0]         count;

  assign full  = (count == (PTR_W+1)'(DEPTH));
  assign empty = (count == '0);
  assign level = count;

  // Full is judged on the registered count, so a same-cycle pop never frees a slot.
  assign push = wr_en && !full && !flush;

  sync_fifo_ptr #(
    .DEPTH (DEPTH),
    .W     (UART_DATA_W)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data (wr_data),
    .pop       (pop),
    .flush     (flush),
    .head_data (head_data),
    .count     (count)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_IDLE;
      out_byte <= '0;
      overflow <= 1'b0;
    end else begin
      state <= state_next;
      if (pop) begin
        out_byte <= head_data;
      end
      if (wr_en && full && !flush) begin
        overflow <= 1'b1;
      end else if (ovf_clr) begin
        overflow <= 1'b0;
      end
    end
  end

  always_comb begin
    state_next  = state;
    pop         = 1'b0;
    uart_dat_we = 1'b0;
    case (state)
      ST_IDLE: begin
        if (!empty && !flush) begin
          pop        = 1'b1;
          state_next = ST_REQ;
        end
      end
      ST_REQ: begin
        uart_dat_we = 1'b1;
        if (uart_dat_ack) begin
          if (!empty && !flush) begin
            pop = 1'b1;
          end else begin
            state_next = ST_IDLE;
          end
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  assign busy        = (state == ST_REQ);
  assign uart_dat_di = {{(UART_BUS_W-UART_DATA_W){1'b0}}, out_byte};

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb/tb_uart_tx_fifo.sv - queue-model bench for uart_tx_fifo with directed scenarios
module tb_uart_tx_fifo;

  localparam int DEPTH = 16;
  localparam int PTR_W = $clog2(DEPTH);

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             wr_en = 1'b0;
  logic [7:0]       wr_data = 8'h00;
  logic             flush = 1'b0;
  logic             ovf_clr = 1'b0;
  logic             uart_dat_ack = 1'b0;
  logic             full;
  logic             empty;
  logic [PTR_W:0]   level;
  logic             overflow;
  logic             busy;
  logic             uart_dat_we;
  logic [31:0]      uart_dat_di;

  int checks = 0;
  int errors = 0;
  bit chk_en = 0;
  int max_lvl = 0;

  // Reference: a byte queue, the byte on the wire, and the sticky flag.
  byte unsigned mq[$];
  byte unsigned dlv_q[$];
  bit           m_req = 0;
  byte unsigned m_byte = 0;
  bit           m_ovf = 0;
  int           m_n;
  bit           m_pop;

  uart_tx_fifo #(.DEPTH(DEPTH)) dut (
    .clk          (clk),
    .reset        (reset),
    .wr_en        (wr_en),
    .wr_data      (wr_data),
    .flush        (flush),
    .full         (full),
    .empty        (empty),
    .level        (level),
    .overflow     (overflow),
    .ovf_clr      (ovf_clr),
    .busy         (busy),
    .uart_dat_we  (uart_dat_we),
    .uart_dat_di  (uart_dat_di),
    .uart_dat_ack (uart_dat_ack)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  always @(posedge clk) begin
    if (reset) begin
      mq.delete();
      m_req  = 0;
      m_byte = 0;
      m_ovf  = 0;
    end else begin
      m_n   = mq.size();
      m_pop = 0;
      if (m_req && uart_dat_ack) dlv_q.push_back(m_byte);
      if (!m_req) begin
        m_pop = (m_n > 0) && !flush;
      end else if (uart_dat_ack) begin
        m_pop = (m_n > 0) && !flush;
        if (!m_pop) m_req = 0;
      end
      if (wr_en && m_n == DEPTH && !flush) m_ovf = 1;
      else if (ovf_clr) m_ovf = 0;
      if (m_pop) begin
        m_byte = mq.pop_front();
        m_req  = 1;
      end
      if (flush) mq.delete();
      else if (wr_en && m_n < DEPTH) mq.push_back(wr_data);
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("m_level", 32'(level), 32'(mq.size()));
      chk("m_full", 32'(full), 32'(mq.size() == DEPTH));
      chk("m_empty", 32'(empty), 32'(mq.size() == 0));
      chk("m_ovf", 32'(overflow), 32'(m_ovf));
      chk("m_we", 32'(uart_dat_we), 32'(m_req));
      chk("m_busy", 32'(busy), 32'(m_req));
      if (m_req) chk("m_di", uart_dat_di, {24'h0, m_byte});
      if (int'(level) > max_lvl) max_lvl = int'(level);
    end
  end

  task automatic tick;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic push_byte(input logic [7:0] d);
    wr_en   = 1'b1;
    wr_data = d;
    tick();
    wr_en   = 1'b0;
  endtask

  task automatic ack_pulse;
    uart_dat_ack = 1'b1;
    tick();
    uart_dat_ack = 1'b0;
  endtask

  initial begin
    int edges;
    @(negedge clk);
    tick();
    tick();
    reset = 1'b0;
    chk_en = 1;

    // 1: reset values, single byte latency and handshake
    chk("rst_level", 32'(level), 32'd0);
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_full", 32'(full), 32'd0);
    chk("rst_we", 32'(uart_dat_we), 32'd0);
    chk("rst_di", uart_dat_di, 32'h0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_ovf", 32'(overflow), 32'd0);
    push_byte(8'h41);
    chk("t1_empty_after_push", 32'(empty), 32'd0);
    edges = 1;
    while (!uart_dat_we && edges < 10) begin
      tick();
      edges++;
    end
    chk("t1_we_latency", 32'(edges), 32'd2);
    chk("t1_di", uart_dat_di, 32'h41);
    tick();
    ack_pulse();
    chk("t1_we_drop", 32'(uart_dat_we), 32'd0);
    chk("t1_busy_drop", 32'(busy), 32'd0);
    chk("t1_empty", 32'(empty), 32'd1);
    chk("t1_dlv", 32'(dlv_q.size() == 1 ? dlv_q[0] : 8'hxx), 32'h41);

    // 2: burst of four, back-to-back acks
    dlv_q.delete();
    max_lvl = 0;
    for (int i = 0; i < 4; i++) push_byte(8'h10 + 8'(i));
    for (int b = 0; b < 4; b++) begin
      for (int c = 0; c < 4; c++) begin
        chk("t2_we_hold", 32'(uart_dat_we), 32'd1);
        tick();
      end
      ack_pulse();
    end
    chk("t2_we_end", 32'(uart_dat_we), 32'd0);
    chk("t2_peak", 32'(max_lvl), 32'd3);
    chk("t2_cnt", 32'(dlv_q.size()), 32'd4);
    for (int i = 0; i < 4 && i < dlv_q.size(); i++) chk("t2_order", 32'(dlv_q[i]), 32'h10 + 32'(i));

    // 3: overfill with ack held low
    dlv_q.delete();
    for (int i = 0; i < 18; i++) push_byte(8'(i));
    chk("t3_full", 32'(full), 32'd1);
    chk("t3_ovf", 32'(overflow), 32'd1);
    chk("t3_level", 32'(level), 32'd16);
    chk("t3_di", uart_dat_di, 32'h00);
    for (int i = 0; i < 17; i++) begin
      ack_pulse();
      tick();
    end
    chk("t3_cnt", 32'(dlv_q.size()), 32'd17);
    for (int i = 0; i < 17 && i < dlv_q.size(); i++) chk("t3_order", 32'(dlv_q[i]), 32'(i));
    chk("t3_idle", 32'(uart_dat_we), 32'd0);
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    chk("t3_ovf_clr", 32'(overflow), 32'd0);

    // 4: flush plus push while a byte is in flight
    dlv_q.delete();
    for (int i = 0; i < 6; i++) push_byte(8'h20 + 8'(i));
    chk("t4_level5", 32'(level), 32'd5);
    wr_en = 1'b1;
    wr_data = 8'hEE;
    flush = 1'b1;
    tick();
    wr_en = 1'b0;
    flush = 1'b0;
    chk("t4_level0", 32'(level), 32'd0);
    chk("t4_ovf", 32'(overflow), 32'd0);
    chk("t4_still_req", 32'(uart_dat_we), 32'd1);
    ack_pulse();
    repeat (4) tick();
    chk("t4_idle", 32'(uart_dat_we), 32'd0);
    chk("t4_cnt", 32'(dlv_q.size()), 32'd1);
    chk("t4_byte", 32'(dlv_q.size() > 0 ? dlv_q[0] : 8'hxx), 32'h20);

    // 5: full FIFO, pop and push in the same cycle
    dlv_q.delete();
    for (int i = 0; i < 17; i++) push_byte(8'h30 + 8'(i));
    chk("t5_full", 32'(full), 32'd1);
    uart_dat_ack = 1'b1;
    wr_en = 1'b1;
    wr_data = 8'hFF;
    tick();
    uart_dat_ack = 1'b0;
    wr_en = 1'b0;
    chk("t5_ovf", 32'(overflow), 32'd1);
    chk("t5_level", 32'(level), 32'd15);
    chk("t5_di", uart_dat_di, 32'h31);
    for (int i = 0; i < 16; i++) begin
      ack_pulse();
      tick();
    end
    chk("t5_cnt", 32'(dlv_q.size()), 32'd17);
    for (int i = 0; i < 17 && i < dlv_q.size(); i++) chk("t5_order", 32'(dlv_q[i]), 32'h30 + 32'(i));

    // 6: reset during a request; overflow is still set from the previous step
    dlv_q.delete();
    for (int i = 0; i < 5; i++) push_byte(8'h50 + 8'(i));
    chk("t6_level4", 32'(level), 32'd4);
    chk("t6_pre_ovf", 32'(overflow), 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("t6_we", 32'(uart_dat_we), 32'd0);
    chk("t6_level", 32'(level), 32'd0);
    chk("t6_busy", 32'(busy), 32'd0);
    chk("t6_ovf", 32'(overflow), 32'd0);
    ack_pulse();
    tick();
    chk("t6_ack_ignored", 32'(uart_dat_we), 32'd0);
    chk("t6_level_after", 32'(level), 32'd0);
    chk("t6_cnt", 32'(dlv_q.size()), 32'd0);

    chk_en = 0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout actual=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
Transmit byte buffer upstream of the serial UART core. It accepts bytes from the CPU or bus side into a power-of-two FIFO and drives the UART core's data write strobe one byte at a time. A byte is held on the strobe until the core acknowledges it. Software can queue a burst of bytes without polling the UART's busy state.

Parameters:
DEPTH, 16, FIFO entries; power of two, minimum 2.
PTR_W, $clog2(DEPTH), pointer width; derived, never overridden.

Ports:
clk  in  1  system clock; all logic on rising edge
reset  in  1  synchronous, active-high reset
wr_en  in  1  push request from bus side
wr_data  in  8  byte to push
flush  in  1  discard all FIFO contents
full  out  1  FIFO holds DEPTH entries
empty  out  1  FIFO holds 0 entries
level  out  PTR_W+1  current FIFO entry count, 0..DEPTH
overflow  out  1  sticky flag: a push was dropped
ovf_clr  in  1  clears overflow
busy  out  1  a byte is presented to the UART and not yet acked
uart_dat_we  out  1  write strobe to the UART core
uart_dat_di  out  32  {24'h0, byte} to the UART core
uart_dat_ack  in  1  one-cycle acceptance pulse from the UART core

Behaviour:
- Reset (reset=1 at an edge): rd_ptr=wr_ptr=count=0; state=IDLE; out_byte=0; overflow=0. After reset: full=0, empty=1, level=0, busy=0, uart_dat_we=0, uart_dat_di=0. Reset in the middle of a request drops the in-flight byte with no handshake completion.
- full, empty and level decode from the registered count. There is no combinational path from wr_en to full.
- Push: a push occurs when wr_en=1 and full=0. Storage is written at wr_ptr, and wr_ptr increments modulo DEPTH.
- Dropped push: when wr_en=1 and full=0 is false, the byte is discarded and overflow is set. This holds even when a pop occurs in the same cycle; full is evaluated before that cycle's pop.
- overflow: set has priority over ovf_clr in the same cycle.
- Pop: a pop is internal only. It occurs on the IDLE->REQ transition. The head byte is copied to out_byte, and rd_ptr increments modulo DEPTH.
- count update per cycle: +1 on push only, -1 on pop only, unchanged when both or neither occur.
- State machine, 2 states:
  - IDLE: uart_dat_we=0. If empty=0 and flush=0, pop and go to REQ.
  - REQ: uart_dat_we=1, uart_dat_di={24'h0,out_byte}, busy=1.
    - On uart_dat_ack=1 with empty=0 and flush=0: pop the next byte and stay in REQ. This is back-to-back operation.
    - On uart_dat_ack=1 otherwise: go to IDLE.
- uart_dat_di stays stable throughout REQ. uart_dat_ack is ignored in IDLE.
- Latency: a push to an empty, idle FIFO at edge N gives empty=0 after N. The pop happens at edge N+1, and uart_dat_we=1 is visible after N+1.
- flush:
  - Sets rd_ptr=wr_ptr, count=0. flush overrides a push in the same cycle; that byte is discarded and overflow is not set.
  - Does not abort REQ: the in-flight byte still completes its handshake.
- Wrap-around: pointers wrap silently. Full is distinguished from empty by count, not by pointer comparison.

Decomposition:
- Shared package uart_pkg: UART_DATA_W=8, UART_BUS_W=32, and the state enum {ST_IDLE, ST_REQ}.
- One natural sub-module: sync_fifo_ptr, holding the pointer/count/storage logic with push/pop/flush inputs. uart_tx_fifo keeps the state machine and the UART handshake.

Test Plan:
1. Reset, then push 8'h41 with ack returned 1 cycle after the strobe -> uart_dat_we rises exactly 2 edges after the push, uart_dat_di=32'h41; busy clears and we drops the edge after ack; empty=1 afterward.
2. Push 8'h10..8'h13 in consecutive cycles, ack each strobe after 5 cycles -> UART sees 10,11,12,13 in order; we stays high continuously across acks; level peaks at 3.
3. DEPTH=16, hold ack low, push 18 bytes 8'h00..8'h11 -> 1 byte moves to out_byte, 16 are queued, 8'h11 is dropped; full=1, overflow=1; acking all 17 delivers 00..10.
4. wr_en and flush in the same cycle with level=5 while in REQ -> level=0, the pushed byte is absent, overflow unchanged, the in-flight byte still completes on ack, then IDLE.
5. Fill to full, then in one cycle ack (causing a pop) plus wr_en -> push rejected and overflow=1; level goes DEPTH -> DEPTH-1.
6. Assert reset while in REQ with level=4 -> next cycle uart_dat_we=0, level=0, busy=0, overflow=0; a later ack pulse is ignored.
